// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing, pixel/colour types and the
// control word carried alongside the fetch pipeline.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = 800;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = 525;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {
        ST_UNSYNC,
        ST_SYNC
    } sync_state_t;

    // Syncs are active-low, so the idle word keeps them high.
    typedef struct packed {
        logic h_sync;
        logic v_sync;
        logic de;
        logic valid;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{h_sync: 1'b1, v_sync: 1'b1, de: 1'b0, valid: 1'b0};

    function automatic int lat_total(input int mem_lat);
        return mem_lat + 2;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous reset of every stage to RESET_VAL.
module vga_delay_line #(
    parameter int                WIDTH     = 4,
    parameter int                DEPTH     = 3,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage <= {DEPTH{RESET_VAL}};
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_frame_fetch.sv
// Turns timing-generator coordinates into image-memory reads and re-aligns
// sync/DE with the returned pixel data. Row address is tracked incrementally.
module vga_frame_fetch
    import vga_pkg::*;
#(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int SCALE   = 1,
    parameter int MEM_LAT = 1,
    parameter int AW      = $clog2(IMG_W*IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          h_sync,
    input  logic          v_sync,
    input  logic          DE,
    input  logic [9:0]    x_pixel,
    input  logic [9:0]    y_pixel,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    input  logic [23:0]   mem_rdata,
    output logic          h_sync_o,
    output logic          v_sync_o,
    output logic          DE_o,
    output logic [7:0]    r_port,
    output logic [7:0]    g_port,
    output logic [7:0]    b_port
);

    localparam int            L       = lat_total(MEM_LAT);
    localparam coord_t        IMG_W_C = coord_t'(IMG_W);
    localparam coord_t        IMG_H_C = coord_t'(IMG_H);
    localparam logic [AW-1:0] W_A     = AW'(IMG_W);

    coord_t        w_sx, w_sy;
    logic          w_in_img, w_synced, w_fetch;
    logic [AW-1:0] w_row_next, w_addr_next;

    sync_state_t   r_state, w_state_nxt;
    coord_t        r_prev_y;
    logic [AW-1:0] r_row_base;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_rd_en;
    rgb_t          r_rgb;

    ctl_t          w_ctl_in, w_ctl_out;

    assign w_sx     = x_pixel >> (SCALE-1);
    assign w_sy     = y_pixel >> (SCALE-1);
    assign w_in_img = DE && (w_sx < IMG_W_C) && (w_sy < IMG_H_C);
    assign w_fetch  = w_in_img && w_synced;

    // Frame lock: until a y==0 line is seen, row_base is meaningless.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_UNSYNC;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_synced    = 1'b0;
        case (r_state)
            ST_UNSYNC: begin
                if (y_pixel == '0) begin
                    w_state_nxt = ST_SYNC;
                    w_synced    = 1'b1;
                end
            end
            ST_SYNC:   w_synced = 1'b1;
            default:   w_state_nxt = ST_UNSYNC;
        endcase
    end

    // With 2x scaling a source row spans two screen lines; advance on even ones.
    always_comb begin
        w_row_next = r_row_base;
        if (y_pixel == '0) begin
            w_row_next = '0;
        end else if ((y_pixel != r_prev_y) && ((SCALE == 1) || !y_pixel[0])) begin
            w_row_next = r_row_base + W_A;
        end
    end

    assign w_addr_next = w_row_next + AW'(w_sx);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_base  <= '0;
            r_prev_y    <= '0;
            r_mem_addr  <= '0;
            r_mem_rd_en <= 1'b0;
        end else begin
            r_row_base  <= w_row_next;
            r_prev_y    <= y_pixel;
            r_mem_rd_en <= w_fetch;
            if (w_fetch) r_mem_addr <= w_addr_next;
        end
    end

    assign w_ctl_in = '{h_sync: h_sync, v_sync: v_sync, de: DE, valid: w_fetch};

    vga_delay_line #(
        .WIDTH     ($bits(ctl_t)),
        .DEPTH     (L),
        .RESET_VAL (CTL_IDLE)
    ) u_ctl_dly (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_ctl_in),
        .o_q   (w_ctl_out)
    );

    // Read data is captured as it arrives; the delayed valid flag blanks it,
    // so late returns after a reset never reach the pins.
    always_ff @(posedge clk) begin
        if (reset) r_rgb <= '0;
        else       r_rgb <= rgb_t'(mem_rdata);
    end

    assign mem_addr  = r_mem_addr;
    assign mem_rd_en = r_mem_rd_en;
    assign h_sync_o  = w_ctl_out.h_sync;
    assign v_sync_o  = w_ctl_out.v_sync;
    assign DE_o      = w_ctl_out.de;
    assign r_port    = w_ctl_out.valid ? r_rgb.r : 8'h00;
    assign g_port    = w_ctl_out.valid ? r_rgb.g : 8'h00;
    assign b_port    = w_ctl_out.valid ? r_rgb.b : 8'h00;

endmodule

// File: tb/tb_vga_frame_fetch.sv
// Three configurations of vga_frame_fetch share one raster stimulus; each is
// compared every cycle with an arithmetic reference model.
module tb_vga_frame_fetch;

    localparam int CW [3] = '{640, 320, 320};
    localparam int CH [3] = '{480, 240, 240};
    localparam int CS [3] = '{1, 2, 1};
    localparam int CL [3] = '{3, 4, 5};

    logic       clk = 1'b0;
    logic       reset = 1'b1, h_sync = 1'b1, v_sync = 1'b1, de = 1'b0;
    logic [9:0] xp = '0, yp = '0;

    logic [18:0] a0;
    logic [16:0] a1, a2;
    logic        e0, e1, e2;
    logic [23:0] d0, d1, d2;
    logic [2:0]  ho, vo, deo;
    logic [7:0]  ro [3];
    logic [7:0]  go [3];
    logic [7:0]  bo [3];

    int tests = 0, fails = 0, ncyc = 0;

    always #5 clk = ~clk;

    vga_frame_fetch #(.IMG_W(640), .IMG_H(480), .SCALE(1), .MEM_LAT(1)) u0 (
        .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync), .DE(de),
        .x_pixel(xp), .y_pixel(yp), .mem_addr(a0), .mem_rd_en(e0), .mem_rdata(d0),
        .h_sync_o(ho[0]), .v_sync_o(vo[0]), .DE_o(deo[0]),
        .r_port(ro[0]), .g_port(go[0]), .b_port(bo[0]));

    vga_frame_fetch #(.IMG_W(320), .IMG_H(240), .SCALE(2), .MEM_LAT(2)) u1 (
        .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync), .DE(de),
        .x_pixel(xp), .y_pixel(yp), .mem_addr(a1), .mem_rd_en(e1), .mem_rdata(d1),
        .h_sync_o(ho[1]), .v_sync_o(vo[1]), .DE_o(deo[1]),
        .r_port(ro[1]), .g_port(go[1]), .b_port(bo[1]));

    vga_frame_fetch #(.IMG_W(320), .IMG_H(240), .SCALE(1), .MEM_LAT(3)) u2 (
        .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync), .DE(de),
        .x_pixel(xp), .y_pixel(yp), .mem_addr(a2), .mem_rd_en(e2), .mem_rdata(d2),
        .h_sync_o(ho[2]), .v_sync_o(vo[2]), .DE_o(deo[2]),
        .r_port(ro[2]), .g_port(go[2]), .b_port(bo[2]));

    // Image memories: word at address A reads back as {00, A[15:0]}.
    logic [23:0] m0 [1:3];
    logic [23:0] m1 [1:3];
    logic [23:0] m2 [1:3];
    always @(posedge clk) begin
        m0[1] <= {8'h00, a0[15:0]}; m0[2] <= m0[1]; m0[3] <= m0[2];
        m1[1] <= {8'h00, a1[15:0]}; m1[2] <= m1[1]; m1[3] <= m1[2];
        m2[1] <= {8'h00, a2[15:0]}; m2[2] <= m2[1]; m2[3] <= m2[2];
    end
    assign d0 = m0[1];
    assign d1 = m1[2];
    assign d2 = m2[3];

    // Reference model: sync lock, last fetched address, and a history of
    // what each sampled input should produce at the output.
    typedef struct packed {
        logic        h;
        logic        v;
        logic        de;
        logic [23:0] rgb;
    } hs_t;

    localparam hs_t IDLE = '{h: 1'b1, v: 1'b1, de: 1'b0, rgb: 24'h0};
    localparam logic [47:0] RST_VEC = {1'b0, 20'h0, 3'b110, 24'h0};

    bit          msync [3];
    logic        men   [3];
    logic [19:0] maddr [3];
    hs_t         hist  [3][8];

    task automatic model_step(input bit rst);
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                msync[d] = 1'b0;
                men[d]   = 1'b0;
                maddr[d] = '0;
                for (int j = 0; j < 8; j++) hist[d][j] = IDLE;
            end else begin
                int sx, sy, addr;
                bit fl;
                sx = int'(xp) / CS[d];
                sy = int'(yp) / CS[d];
                if (yp == 10'd0) msync[d] = 1'b1;
                fl   = de && (sx < CW[d]) && (sy < CH[d]) && msync[d];
                addr = sy * CW[d] + sx;
                men[d] = fl;
                if (fl) maddr[d] = 20'(addr);
                for (int j = 7; j > 0; j--) hist[d][j] = hist[d][j-1];
                hist[d][0] = '{h: h_sync, v: v_sync, de: de,
                               rgb: fl ? {8'h00, 16'(addr)} : 24'h0};
            end
        end
    endtask

    function automatic logic [47:0] expv(input int d);
        hs_t o;
        o = hist[d][CL[d]-1];
        return {men[d], maddr[d], o.h, o.v, o.de, o.rgb};
    endfunction

    function automatic logic [47:0] obs(input int d);
        case (d)
            0:       return {e0, 20'(a0), ho[0], vo[0], deo[0], ro[0], go[0], bo[0]};
            1:       return {e1, 20'(a1), ho[1], vo[1], deo[1], ro[1], go[1], bo[1]};
            default: return {e2, 20'(a2), ho[2], vo[2], deo[2], ro[2], go[2], bo[2]};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit hs, input bit vs, input bit dv,
                       input int xx, input int yy);
        reset = r; h_sync = hs; v_sync = vs; de = dv;
        xp = 10'(xx); yp = 10'(yy);
        @(posedge clk);
        model_step(r);
        ncyc++;
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk($sformatf("dut%0d cyc%0d", k, ncyc), obs(k), expv(k));
    endtask

    task automatic pix(input int xx, input int yy, input bit dv);
        cyc(1'b0, !(xx >= 656 && xx < 752), !(yy >= 490 && yy < 492), dv, xx, yy);
    endtask

    task automatic rand_line(input int yy);
        int n, xx;
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) begin
            xx = $urandom_range(0, 799);
            pix(xx, yy, (xx < 640 && yy < 480) ? ($urandom_range(0, 3) != 0) : 1'b0);
        end
    endtask

    initial begin
        int first [3];
        int lows  [3];
        int fin;

        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 5);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 5);
        for (int d = 0; d < 3; d++) chk($sformatf("reset dut%0d", d), obs(d), RST_VEC);

        // Frame start: sequential addresses, data three cycles behind on dut0.
        for (int i = 0; i < 8; i++) begin
            pix(i, 0, 1'b1);
            chk("f0 addr", 48'({e0, a0}), 48'({1'b1, 19'(i)}));
            chk("s2 addr", 48'({e1, a1}), 48'({1'b1, 17'(i / 2)}));
            if (i >= 2) chk("f0 rgb", 48'({deo[0], ro[0], go[0], bo[0]}), 48'({1'b1, 24'(i - 2)}));
        end
        pix(0, 1, 1'b1);
        chk("line1 addr", 48'(a0), 48'd640);
        chk("s2 y1 addr", 48'(a1), 48'd0);
        pix(0, 2, 1'b1);
        chk("s2 y2 addr", 48'(a1), 48'd320);

        for (int yy = 2; yy < 525; yy++) begin
            rand_line(yy);
            if (yy == 10) begin
                for (int k = 0; k < 5; k++) begin
                    pix(400, 10, 1'b1);
                    if (k == 0) chk("oob rd_en", 48'(e2), 48'd0);
                end
                chk("oob out", 48'({deo[2], ro[2], go[2], bo[2]}), {23'd0, 1'b1, 24'h0});
            end
            if (yy == 200) begin
                for (int k = 0; k < 5; k++) pix(639, 200, 1'b1);
                for (int d = 0; d < 3; d++) begin first[d] = -1; lows[d] = 0; end
                fin = -1;
                for (int xx = 640; xx < 800; xx++) begin
                    pix(xx, 200, 1'b0);
                    if (xx == 656) fin = xx - 640;
                    for (int d = 0; d < 3; d++) if (!ho[d]) begin
                        lows[d]++;
                        if (first[d] < 0) first[d] = xx - 640;
                    end
                end
                // Observation n reflects stage A of input n, so a lag of L-1
                // observations is L cycles from input to pin.
                for (int d = 0; d < 3; d++) begin
                    chk($sformatf("hsync lag dut%0d", d), 48'(first[d] - fin), 48'(CL[d] - 1));
                    chk($sformatf("hsync width dut%0d", d), 48'(lows[d]), 48'd96);
                end
            end
            if (yy == 479) begin
                pix(639, 479, 1'b1);
                chk("last addr", 48'({e0, a0}), 48'({1'b1, 19'd307199}));
            end
        end

        // Second frame with a one-cycle reset in the middle.
        for (int yy = 0; yy < 100; yy++) rand_line(yy);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 100, 100);
        for (int d = 0; d < 3; d++) chk($sformatf("mid reset dut%0d", d), obs(d), RST_VEC);
        for (int yy = 100; yy < 525; yy++) rand_line(yy);
        pix(0, 0, 1'b1);
        chk("resync addr", 48'({e0, a0}), 48'({1'b1, 19'd0}));
        for (int yy = 0; yy < 20; yy++) rand_line(yy);
        for (int k = 0; k < 6; k++) pix(700, 20, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
